// File: rtl/int_issue_dispatch_tx.sv
// Integer issue-queue write side: compacts renamed ops into a small in-order FIFO and
// sends credit-limited prefix groups. Optional perf counters behind `DISPATCH_PERF_EN`.
module int_issue_dispatch_tx #(
  parameter int unsigned QUEUE_DEPTH = 32,
  parameter int unsigned BUF_DEPTH   = 8,
  parameter int unsigned REN_W       = 7,
  parameter int unsigned MICOP_W     = 8,
  parameter int unsigned IMM_W       = 26,
  parameter int unsigned OP_W        = 3 * (REN_W + 1) + MICOP_W + 1 + IMM_W
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic [3:0]        InValid,
  input  logic [4*OP_W-1:0] InOp,
  output logic              InReady,
  input  logic              IsQuIntStop,
  input  logic              IsQuIntFlash,
  input  logic [2:0]        IssueRelease,
  output logic [3:0]        OutValid,
  output logic [4*OP_W-1:0] OutOp,
`ifdef DISPATCH_PERF_EN
  output logic [31:0]       PerfSent,
  output logic [31:0]       PerfCreditStall,
  output logic [31:0]       PerfFullStall,
`endif
  output logic [5:0]        Credits
);

  localparam int unsigned IdxW = $clog2(BUF_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [OP_W-1:0] mem_q [BUF_DEPTH];
  logic [OP_W-1:0] mem_d [BUF_DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, count;
  logic [5:0]      credits_q, credits_d;
  logic [6:0]      credit_sum;
  logic [2:0]      cnt_lim, nsend, n_in;
  logic [IdxW-1:0] wr_idx, rd_idx;
  logic            accept;

  assign count   = tail_q - head_q;
  assign InReady = !Rest && ((BUF_DEPTH - 32'(count)) >= 32'd4);
  assign accept  = InReady && !IsQuIntFlash;
  assign Credits = credits_q;

  // Send size: bounded by buffered ops, the 4-wide port and downstream credits.
  always_comb begin
    cnt_lim = (count < PtrW'(4)) ? count[2:0] : 3'd4;
    nsend   = cnt_lim;
    if (credits_q < 6'(cnt_lim)) begin
      nsend = credits_q[2:0];
    end
    if (Rest || IsQuIntStop || IsQuIntFlash) begin
      nsend = 3'd0;
    end
  end

  // Valid input slots are packed densely at the tail in slot order.
  always_comb begin
    mem_d  = mem_q;
    n_in   = 3'd0;
    wr_idx = '0;
    for (int k = 0; k < 4; k++) begin
      if (accept && InValid[k]) begin
        wr_idx        = tail_q[IdxW-1:0] + IdxW'(n_in);
        mem_d[wr_idx] = InOp[k*OP_W +: OP_W];
        n_in          = n_in + 3'd1;
      end
    end
  end

  always_comb begin
    OutValid = '0;
    OutOp    = '0;
    rd_idx   = '0;
    for (int j = 0; j < 4; j++) begin
      rd_idx = head_q[IdxW-1:0] + IdxW'(j);
      if (3'(j) < nsend) begin
        OutValid[j]              = 1'b1;
        OutOp[j*OP_W +: OP_W]    = mem_q[rd_idx];
      end
    end
  end

  always_comb begin
    credit_sum = 7'(credits_q) - 7'(nsend) + 7'(IssueRelease);
    credits_d  = (credit_sum > 7'(QUEUE_DEPTH)) ? 6'(QUEUE_DEPTH) : credit_sum[5:0];
    head_d     = head_q + PtrW'(nsend);
    tail_d     = tail_q + PtrW'(n_in);
    if (IsQuIntFlash) begin
      credits_d = 6'(QUEUE_DEPTH);
      head_d    = '0;
      tail_d    = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      head_q    <= '0;
      tail_q    <= '0;
      credits_q <= 6'(QUEUE_DEPTH);
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      credits_q <= credits_d;
      mem_q     <= mem_d;
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_sent_q, perf_credit_stall_q, perf_full_stall_q;

  always_ff @(posedge Clk) begin
    if (Rest || IsQuIntFlash) begin
      perf_sent_q         <= '0;
      perf_credit_stall_q <= '0;
      perf_full_stall_q   <= '0;
    end else begin
      perf_sent_q <= perf_sent_q + 32'(nsend);
      if ((count != '0) && !IsQuIntStop && (credits_q < 6'(cnt_lim))) begin
        perf_credit_stall_q <= perf_credit_stall_q + 32'd1;
      end
      if ((InValid != 4'd0) && !InReady) begin
        perf_full_stall_q <= perf_full_stall_q + 32'd1;
      end
    end
  end

  assign PerfSent        = perf_sent_q;
  assign PerfCreditStall = perf_credit_stall_q;
  assign PerfFullStall   = perf_full_stall_q;
`endif

endmodule
